// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand registers and alu_seq.
// The requester owns start/operands/opcode; the ALU owns handshake status and result.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic                 start_i;
   logic [WIDTH-1:0]     a_i;
   logic [WIDTH-1:0]     b_i;
   logic [2:0]           fct_i;
   logic                 ready_o;
   logic                 valid_o;
   logic [2*WIDTH-1:0]   s_o;
   logic                 signal_o;

   modport master (
      output start_i, a_i, b_i, fct_i,
      input  ready_o, valid_o, s_o, signal_o
   );

   modport slave (
      input  start_i, a_i, b_i, fct_i,
      output ready_o, valid_o, s_o, signal_o
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle add/sub/cmp, iterative shift-add multiply
// and restoring divide sharing one 2*WIDTH work register, with a registered result.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   alu_seq_if.slave  bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [W2-1:0]     p;
   logic [WIDTH-1:0]  opd;
   logic              div_r;
   logic              bz_r;
   logic [CW-1:0]     cnt;

   logic [WIDTH:0]    add_w;
   logic [WIDTH:0]    diff_w;
   logic [W2-1:0]     s_one;
   logic              sig_one;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    sh;
   logic [WIDTH:0]    trial;
   logic [W2-1:0]     p_nxt;

   // Single-cycle results straight from the live operands at accept.
   always_comb begin
      add_w   = {1'b0, bus.a_i} + {1'b0, bus.b_i};
      diff_w  = {1'b0, bus.a_i} - {1'b0, bus.b_i};
      s_one   = '0;
      sig_one = 1'b1;
      case (bus.fct_i)
         3'b000: begin
            s_one   = {{(WIDTH-1){1'b0}}, add_w};
            sig_one = add_w[WIDTH];
         end
         3'b001: begin
            s_one   = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
            sig_one = diff_w[WIDTH];
         end
         3'b011: sig_one = (bus.a_i == bus.b_i);
         default: ;
      endcase
   end

   // One iteration: mul keeps {hi, multiplier} and shifts right;
   // div keeps {rem, dividend/quotient} and shifts left, MSB first.
   always_comb begin
      mul_sum = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      sh      = {p[W2-1:WIDTH], p[WIDTH-1]};
      trial   = sh - {1'b0, opd};
      if (div_r) begin
         if (trial[WIDTH]) p_nxt = {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
         else              p_nxt = {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      end else begin
         p_nxt = {mul_sum, p[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         bus.ready_o  <= 1'b1;
         bus.valid_o  <= 1'b0;
         bus.s_o      <= '0;
         bus.signal_o <= 1'b0;
         p            <= '0;
         opd          <= '0;
         div_r        <= 1'b0;
         bz_r         <= 1'b0;
         cnt          <= '0;
      end else begin
         bus.valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  bus.ready_o <= 1'b0;
                  if (bus.fct_i == 3'b010 || bus.fct_i == 3'b100) begin
                     state <= CALC;
                     div_r <= bus.fct_i[2];
                     bz_r  <= (bus.b_i == '0);
                     opd   <= bus.fct_i[2] ? bus.b_i : bus.a_i;
                     p     <= {{WIDTH{1'b0}}, (bus.fct_i[2] ? bus.a_i : bus.b_i)};
                     cnt   <= '0;
                  end else begin
                     state        <= DONE;
                     bus.valid_o  <= 1'b1;
                     bus.s_o      <= s_one;
                     bus.signal_o <= sig_one;
                  end
               end
            end
            CALC: begin
               p   <= p_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  state       <= DONE;
                  bus.valid_o <= 1'b1;
                  // Divide-by-zero runs the full latency, then reports saturation.
                  if (div_r && bz_r) begin
                     bus.s_o      <= '1;
                     bus.signal_o <= 1'b1;
                  end else begin
                     bus.s_o      <= p_nxt;
                     bus.signal_o <= 1'b0;
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               bus.ready_o <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               bus.ready_o <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq at WIDTH 8, 4 and 16 against an
// arithmetic reference model.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  i8 ();
   alu_seq_if #(.WIDTH(4))  i4 ();
   alu_seq_if #(.WIDTH(16)) i16 ();

   alu_seq #(.WIDTH(8))  u8  (.clk_i(clk), .rst_n_i(rst_n), .bus(i8.slave));
   alu_seq #(.WIDTH(4))  u4  (.clk_i(clk), .rst_n_i(rst_n), .bus(i4.slave));
   alu_seq #(.WIDTH(16)) u16 (.clk_i(clk), .rst_n_i(rst_n), .bus(i16.slave));

   function automatic logic [63:0] ref_s(input int w, input logic [2:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] aa, bb, m2;
      aa = {32'd0, a};
      bb = {32'd0, b};
      m2 = (64'd1 << (2 * w)) - 64'd1;
      case (f)
         3'd0: return aa + bb;
         3'd1: return (aa - bb) & m2;
         3'd2: return aa * bb;
         3'd4: return (bb == 64'd0) ? m2 : (((aa % bb) << w) | (aa / bb));
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] ref_sig(input int w, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [63:0] aa, bb;
      aa = {32'd0, a};
      bb = {32'd0, b};
      case (f)
         3'd0: return ((aa + bb) >> w) & 64'd1;
         3'd1: return {63'd0, aa < bb};
         3'd2: return 64'd0;
         3'd3: return {63'd0, aa == bb};
         3'd4: return {63'd0, bb == 64'd0};
         default: return 64'd1;
      endcase
   endfunction

   function automatic int ref_lat(input int w, input logic [2:0] f);
      return (f == 3'd2 || f == 3'd4) ? w + 1 : 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request on the 8-bit unit; lat = cycles from accept edge to valid_o.
   task automatic op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
      i8.start_i = 1'b1;
      i8.fct_i   = f;
      i8.a_i     = a;
      i8.b_i     = b;
      step();
      i8.start_i = 1'b0;
      lat = 1;
      while (!i8.valid_o && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic rnd4(input int n);
      logic [3:0] a, b;
      logic [2:0] f;
      int lat;
      for (int k = 0; k < n; k++) begin
         a = 4'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         f = 3'($urandom_range(0, 7));
         i4.start_i = 1'b1;
         i4.fct_i   = f;
         i4.a_i     = a;
         i4.b_i     = b;
         step();
         i4.start_i = 1'b0;
         i4.a_i     = 4'($urandom);
         lat = 1;
         while (!i4.valid_o && lat < 40) begin
            step();
            lat++;
         end
         chk("w4_s", 64'(i4.s_o), ref_s(4, f, 32'(a), 32'(b)));
         chk("w4_sig", 64'(i4.signal_o), ref_sig(4, f, 32'(a), 32'(b)));
         chk("w4_lat", 64'(lat), 64'(ref_lat(4, f)));
         step();
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic rnd16(input int n);
      logic [15:0] a, b;
      logic [2:0]  f;
      int lat;
      for (int k = 0; k < n; k++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 14));
         f = 3'($urandom_range(0, 7));
         i16.start_i = 1'b1;
         i16.fct_i   = f;
         i16.a_i     = a;
         i16.b_i     = b;
         step();
         i16.start_i = 1'b0;
         i16.b_i     = 16'($urandom);
         lat = 1;
         while (!i16.valid_o && lat < 60) begin
            step();
            lat++;
         end
         chk("w16_s", 64'(i16.s_o), ref_s(16, f, 32'(a), 32'(b)));
         chk("w16_sig", 64'(i16.signal_o), ref_sig(16, f, 32'(a), 32'(b)));
         chk("w16_lat", 64'(lat), 64'(ref_lat(16, f)));
         step();
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   initial begin
      int lat;
      int nv;
      int rdy_bad;
      i8.start_i  = 1'b0;  i8.a_i  = '0; i8.b_i  = '0; i8.fct_i  = '0;
      i4.start_i  = 1'b0;  i4.a_i  = '0; i4.b_i  = '0; i4.fct_i  = '0;
      i16.start_i = 1'b0;  i16.a_i = '0; i16.b_i = '0; i16.fct_i = '0;

      // Reset state
      repeat (3) step();
      chk("rst_ready", 64'(i8.ready_o), 64'd1);
      chk("rst_valid", 64'(i8.valid_o), 64'd0);
      chk("rst_s", 64'(i8.s_o), 64'd0);
      chk("rst_sig", 64'(i8.signal_o), 64'd0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", 64'(i8.ready_o), 64'd1);

      // ADD with carry out, ready drops while the result is presented
      op8(3'b000, 8'hFF, 8'h01, lat);
      chk("add_lat", 64'(lat), 64'd1);
      chk("add_s", 64'(i8.s_o), 64'h0100);
      chk("add_sig", 64'(i8.signal_o), 64'd1);
      chk("add_busy", 64'(i8.ready_o), 64'd0);
      step();
      chk("add_ready_back", 64'(i8.ready_o), 64'd1);
      chk("add_valid_pulse", 64'(i8.valid_o), 64'd0);
      chk("add_s_held", 64'(i8.s_o), 64'h0100);

      // SUB borrow and CMP equal
      op8(3'b001, 8'd5, 8'd15, lat);
      chk("sub_s", 64'(i8.s_o), 64'hFFF6);
      chk("sub_sig", 64'(i8.signal_o), 64'd1);
      step();
      op8(3'b011, 8'd15, 8'd15, lat);
      chk("cmp_s", 64'(i8.s_o), 64'd0);
      chk("cmp_sig", 64'(i8.signal_o), 64'd1);
      step();

      // MUL with start held and operand A toggling through CALC
      i8.start_i = 1'b1; i8.fct_i = 3'b010; i8.a_i = 8'hFF; i8.b_i = 8'hFF;
      step();
      lat = 1;
      while (!i8.valid_o && lat < 40) begin
         i8.a_i = ~i8.a_i;
         step();
         lat++;
      end
      i8.start_i = 1'b0;
      chk("mul_lat", 64'(lat), 64'd9);
      chk("mul_s", 64'(i8.s_o), 64'hFE01);
      chk("mul_sig", 64'(i8.signal_o), 64'd0);
      nv = 0;
      repeat (12) begin
         step();
         if (i8.valid_o) nv++;
      end
      chk("mul_one_valid", 64'(nv), 64'd0);
      chk("mul_s_stable", 64'(i8.s_o), 64'hFE01);

      // DIV normal and divide-by-zero
      op8(3'b100, 8'd200, 8'd7, lat);
      chk("div_lat", 64'(lat), 64'd9);
      chk("div_s", 64'(i8.s_o), 64'h041C);
      chk("div_sig", 64'(i8.signal_o), 64'd0);
      step();
      op8(3'b100, 8'd9, 8'd0, lat);
      chk("div0_lat", 64'(lat), 64'd9);
      chk("div0_s", 64'(i8.s_o), 64'hFFFF);
      chk("div0_sig", 64'(i8.signal_o), 64'd1);
      step();

      // Reset three cycles into a MUL aborts it
      i8.start_i = 1'b1; i8.fct_i = 3'b010; i8.a_i = 8'h37; i8.b_i = 8'h5A;
      step();
      i8.start_i = 1'b0;
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk("abort_s", 64'(i8.s_o), 64'd0);
      chk("abort_sig", 64'(i8.signal_o), 64'd0);
      chk("abort_ready", 64'(i8.ready_o), 64'd1);
      repeat (2) step();
      rst_n = 1'b1;
      nv = 0;
      rdy_bad = 0;
      repeat (12) begin
         step();
         if (i8.valid_o) nv++;
         if (!i8.ready_o) rdy_bad++;
      end
      chk("abort_no_valid", 64'(nv), 64'd0);
      chk("abort_ready_held", 64'(rdy_bad), 64'd0);
      op8(3'b000, 8'd2, 8'd3, lat);
      chk("post_add_lat", 64'(lat), 64'd1);
      chk("post_add_s", 64'(i8.s_o), 64'd5);
      chk("post_add_sig", 64'(i8.signal_o), 64'd0);
      step();

      // Illegal opcode
      op8(3'b111, 8'hA5, 8'h3C, lat);
      chk("ill_lat", 64'(lat), 64'd1);
      chk("ill_s", 64'(i8.s_o), 64'd0);
      chk("ill_sig", 64'(i8.signal_o), 64'd1);
      step();

      // Back-to-back single-cycle ops: accept every second cycle
      i8.start_i = 1'b1; i8.fct_i = 3'b000; i8.a_i = 8'd10; i8.b_i = 8'd20;
      step();
      chk("b2b_v1", 64'(i8.valid_o), 64'd1);
      chk("b2b_s1", 64'(i8.s_o), 64'd30);
      i8.a_i = 8'd40;
      step();
      chk("b2b_idle", 64'(i8.ready_o), 64'd1);
      step();
      i8.start_i = 1'b0;
      chk("b2b_v2", 64'(i8.valid_o), 64'd1);
      chk("b2b_s2", 64'(i8.s_o), 64'd60);
      step();

      rnd4(1000);
      rnd16(1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
